processor: RTL and testbench

PROCESSOR -- requirements
Module: processor

---
 rtl/processor.sv | 98 +++++++++
 tb/tb_processor.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/processor.sv
// rtl/processor.sv - multi-cycle 16-bit processor: 8 registers, mv/mvi/add/sub over a shared bus
module processor (
  input  logic        clk,
  input  logic        Resetn,
  input  logic [15:0] DIN,
  input  logic        Run,
  output logic        Done,
  output logic [15:0] BUS
);

  typedef enum logic [1:0] {T0, T1, T2, T3} step_t;

  step_t       step, step_n;
  logic [8:0]  ir;
  logic [15:0] a, g;
  logic [15:0] r [8];

  logic        ir_ld, a_ld, g_ld, r_we;
  logic [2:0]  op, x, y;

  assign op = ir[8:6];
  assign x  = ir[5:3];
  assign y  = ir[2:0];

  always_comb begin
    step_n = step;
    BUS    = 16'h0000;
    Done   = 1'b0;
    ir_ld  = 1'b0;
    a_ld   = 1'b0;
    g_ld   = 1'b0;
    r_we   = 1'b0;
    case (step)
      T0: begin
        if (Run) begin
          ir_ld  = 1'b1;
          step_n = T1;
        end
      end
      T1: begin
        case (op)
          3'b000: begin
            BUS    = r[y];
            r_we   = 1'b1;
            Done   = 1'b1;
            step_n = T0;
          end
          3'b001: begin
            BUS    = DIN;
            r_we   = 1'b1;
            Done   = 1'b1;
            step_n = T0;
          end
          3'b010, 3'b011: begin
            BUS    = r[x];
            a_ld   = 1'b1;
            step_n = T2;
          end
          default: begin
            Done   = 1'b1;
            step_n = T0;
          end
        endcase
      end
      // T2/T3 are only reachable from add or sub
      T2: begin
        BUS    = r[y];
        g_ld   = 1'b1;
        step_n = T3;
      end
      T3: begin
        BUS    = g;
        r_we   = 1'b1;
        Done   = 1'b1;
        step_n = T0;
      end
      default: step_n = T0;
    endcase
  end

  always_ff @(posedge clk or negedge Resetn) begin
    if (!Resetn) begin
      step <= T0;
      ir   <= 9'd0;
      a    <= 16'h0000;
      g    <= 16'h0000;
      for (int i = 0; i < 8; i++) r[i] <= 16'h0000;
    end else begin
      step <= step_n;
      if (ir_ld) ir <= DIN[8:0];
      if (a_ld)  a  <= BUS;
      // op[0] distinguishes sub (011) from add (010)
      if (g_ld)  g  <= op[0] ? (a - BUS) : (a + BUS);
      if (r_we)  r[x] <= BUS;
    end
  end

endmodule

// File: tb/tb_processor.sv
// tb/tb_processor.sv - directed self-checking bench for processor
module tb_processor;

  logic        clk;
  logic        Resetn;
  logic [15:0] DIN;
  logic        Run;
  logic        Done;
  logic [15:0] BUS;

  int tests;
  int fails;

  processor dut (
    .clk    (clk),
    .Resetn (Resetn),
    .DIN    (DIN),
    .Run    (Run),
    .Done   (Done),
    .BUS    (BUS)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] enc(input logic [2:0] op, input logic [2:0] x, input logic [2:0] y);
    return {7'b0, op, x, y};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present an instruction in T0, return one time unit into T1
  task automatic issue(input string tag, input logic [15:0] instr);
    Run = 1'b1;
    DIN = instr;
    #1;
    chk({tag, "_t0_done"}, {15'b0, Done}, 16'h0000);
    chk({tag, "_t0_bus"}, BUS, 16'h0000);
    @(posedge clk);
    #1;
    Run = 1'b0;
    DIN = 16'hDEAD;
  endtask

  task automatic mvi(input string tag, input logic [15:0] instr, input logic [15:0] imm);
    issue(tag, instr);
    DIN = imm;
    #1;
    chk({tag, "_t1_bus"}, BUS, imm);
    chk({tag, "_t1_done"}, {15'b0, Done}, 16'h0001);
    @(posedge clk);
    #1;
  endtask

  task automatic mv(input string tag, input logic [15:0] instr, input logic [15:0] exp);
    issue(tag, instr);
    #1;
    chk({tag, "_t1_bus"}, BUS, exp);
    chk({tag, "_t1_done"}, {15'b0, Done}, 16'h0001);
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string tag, input logic [2:0] y, input logic [15:0] exp);
    mv(tag, enc(3'b000, y, y), exp);
  endtask

  task automatic arith(input string tag, input logic [15:0] instr,
                       input logic [15:0] e1, input logic [15:0] e2, input logic [15:0] e3);
    issue(tag, instr);
    #1;
    chk({tag, "_t1_bus"}, BUS, e1);
    chk({tag, "_t1_done"}, {15'b0, Done}, 16'h0000);
    @(posedge clk);
    #1;
    chk({tag, "_t2_bus"}, BUS, e2);
    chk({tag, "_t2_done"}, {15'b0, Done}, 16'h0000);
    @(posedge clk);
    #1;
    chk({tag, "_t3_bus"}, BUS, e3);
    chk({tag, "_t3_done"}, {15'b0, Done}, 16'h0001);
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests  = 0;
    fails  = 0;
    Resetn = 1'b1;
    Run    = 1'b0;
    DIN    = 16'h0000;
    #1;
    Resetn = 1'b0;
    #3;
    chk("reset_done", {15'b0, Done}, 16'h0000);
    chk("reset_bus", BUS, 16'h0000);
    #8;
    Resetn = 1'b1;

    for (int i = 0; i < 8; i++) rd($sformatf("reset_r%0d", i), 3'(i), 16'h0000);

    mvi("mvi_r0", 16'h0040, 16'hAAAA);
    mv("mv_r1_r0", 16'h0008, 16'hAAAA);
    rd("rd_r0_a", 3'd0, 16'hAAAA);
    rd("rd_r1_a", 3'd1, 16'hAAAA);

    mvi("mvi_r0_5", 16'h0040, 16'h5555);
    arith("add_r0_r1", 16'h0081, 16'h5555, 16'hAAAA, 16'hFFFF);
    rd("rd_r0_add", 3'd0, 16'hFFFF);
    arith("sub_r0_r1", 16'h00C1, 16'hFFFF, 16'hAAAA, 16'h5555);
    rd("rd_r0_sub", 3'd0, 16'h5555);

    mvi("mvi_r2_ffff", enc(3'b001, 3'd2, 3'd0), 16'hFFFF);
    mvi("mvi_r3_1", enc(3'b001, 3'd3, 3'd0), 16'h0001);
    arith("add_wrap", enc(3'b010, 3'd2, 3'd3), 16'hFFFF, 16'h0001, 16'h0000);
    rd("rd_r2_wrap_add", 3'd2, 16'h0000);
    mvi("mvi_r2_1", enc(3'b001, 3'd2, 3'd0), 16'h0001);
    mvi("mvi_r3_2", enc(3'b001, 3'd3, 3'd0), 16'h0002);
    arith("sub_wrap", enc(3'b011, 3'd2, 3'd3), 16'h0001, 16'h0002, 16'hFFFF);
    rd("rd_r2_wrap_sub", 3'd2, 16'hFFFF);

    arith("add_xy_same", enc(3'b010, 3'd3, 3'd3), 16'h0002, 16'h0002, 16'h0004);
    rd("rd_r3_double", 3'd3, 16'h0004);
    arith("sub_xy_same", enc(3'b011, 3'd3, 3'd3), 16'h0004, 16'h0004, 16'h0000);
    rd("rd_r3_zero", 3'd3, 16'h0000);

    mv("nop_100", enc(3'b100, 3'd0, 3'd1), 16'h0000);
    mv("nop_111", enc(3'b111, 3'd0, 3'd1), 16'h0000);
    rd("rd_r0_nop", 3'd0, 16'h5555);

    Run = 1'b0;
    DIN = 16'hFFFF;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("idle%0d_done", i), {15'b0, Done}, 16'h0000);
      chk($sformatf("idle%0d_bus", i), BUS, 16'h0000);
      @(posedge clk);
      #1;
    end
    rd("rd_r1_idle", 3'd1, 16'hAAAA);

    mvi("mvi_r4", enc(3'b001, 3'd4, 3'd0), 16'h1234);
    mvi("mvi_r5", enc(3'b001, 3'd5, 3'd0), 16'h0001);
    issue("abort_add", enc(3'b010, 3'd4, 3'd5));
    #1;
    chk("abort_t1_bus", BUS, 16'h1234);
    @(posedge clk);
    #1;
    chk("abort_t2_bus", BUS, 16'h0001);
    Resetn = 1'b0;
    #1;
    chk("abort_rst_done", {15'b0, Done}, 16'h0000);
    chk("abort_rst_bus", BUS, 16'h0000);
    @(posedge clk);
    #1;
    chk("abort_hold_bus", BUS, 16'h0000);
    Resetn = 1'b1;
    #1;
    rd("rd_r4_abort", 3'd4, 16'h0000);
    rd("rd_r5_abort", 3'd5, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
